// File: rtl/regfile_sb.sv
// regfile_sb: register file with busy-bit scoreboard, writeback bypass and operand-B immediate mux.
//   clk, rst_n                   clock, asynchronous active-low reset
//   regread_dest1/2 -> A, OP2    combinational register reads
//   isImmediate, immx -> B       B = immx when isImmediate, else OP2
//   regwrite_en/dest/data        writeback port
//   issue_valid/wb/rd -> stall   RAW/WAW hazard check for the issuing instruction
//   busy_count                   number of registers with a writer in flight
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int AW = 4,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   regread_dest1,
  input  logic [AW-1:0]   regread_dest2,
  input  logic            isImmediate,
  input  logic [XLEN-1:0] immx,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] OP2,
  output logic [XLEN-1:0] B,
  input  logic            regwrite_en,
  input  logic [AW-1:0]   regwrite_dest,
  input  logic [XLEN-1:0] regwrite_data,
  input  logic            issue_valid,
  input  logic            issue_wb,
  input  logic [AW-1:0]   issue_rd,
  output logic            stall,
  output logic [AW:0]     busy_count
);
  localparam int NREGS = 2**AW;
  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d, beff;
  logic [AW:0]      busy_count_q, busy_count_d;
  logic             byp1, byp2, accept;
  assign byp1 = BYPASS && regwrite_en && regwrite_dest == regread_dest1;
  assign byp2 = BYPASS && regwrite_en && regwrite_dest == regread_dest2;
  assign A   = (ZERO_REG && regread_dest1 == '0) ? '0 : byp1 ? regwrite_data : regs_q[regread_dest1];
  assign OP2 = (ZERO_REG && regread_dest2 == '0) ? '0 : byp2 ? regwrite_data : regs_q[regread_dest2];
  assign B   = isImmediate ? immx : OP2;
  // a writeback landing this cycle already satisfies any consumer when bypassing
  always_comb begin
    beff = busy_q;
    if (BYPASS && regwrite_en) beff[regwrite_dest] = 1'b0;
    if (ZERO_REG) beff[0] = 1'b0;
  end
  assign stall = issue_valid & (beff[regread_dest1] | (~isImmediate & beff[regread_dest2])
                                | (issue_wb & beff[issue_rd]));
  assign accept = issue_valid & ~stall;
  // clear before set so a same-index issue (the younger writer) keeps the bit
  always_comb begin
    busy_d = busy_q;
    if (regwrite_en) busy_d[regwrite_dest] = 1'b0;
    if (accept && issue_wb && !(ZERO_REG && issue_rd == '0)) busy_d[issue_rd] = 1'b1;
    busy_count_d = '0;
    for (int i = 0; i < NREGS; i++) busy_count_d = busy_count_d + (AW+1)'(busy_d[i]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q <= '0;
      busy_count_q <= '0;
    end else begin
      if (regwrite_en && !(ZERO_REG && regwrite_dest == '0)) regs_q[regwrite_dest] <= regwrite_data;
      busy_q <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end
  assign busy_count = busy_count_q;
endmodule
